// File: rtl/mc_ctrl_fsm_pkg.sv
// mc_ctrl_fsm_pkg: state encodings, opcode constants, ALU opcodes and opcode classing
package mc_ctrl_fsm_pkg;

    localparam int STATE_W = 4;
    localparam int CNT_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        S_IF, S_ID, S_EX, S_MEM, S_WB, S_JR, S_PCINC, S_HALT
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] alu_ADD  = 4'd0;
    localparam logic [3:0] alu_SUB  = 4'd1;
    localparam logic [3:0] alu_SLL  = 4'd2;
    localparam logic [3:0] alu_SLT  = 4'd3;
    localparam logic [3:0] alu_SLTU = 4'd4;
    localparam logic [3:0] alu_XOR  = 4'd5;
    localparam logic [3:0] alu_SRL  = 4'd6;
    localparam logic [3:0] alu_SRA  = 4'd7;
    localparam logic [3:0] alu_OR   = 4'd8;
    localparam logic [3:0] alu_AND  = 4'd9;
    localparam logic [3:0] alu_BEQ  = 4'd10;
    localparam logic [3:0] alu_BNE  = 4'd11;
    localparam logic [3:0] alu_BLT  = 4'd12;
    localparam logic [3:0] alu_BGE  = 4'd13;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_SYS, C_OTHER
    } op_class_e;

    function automatic op_class_e op_class(input logic [6:0] opcode);
        return opcode == OP_R      ? C_R      :
               opcode == OP_I      ? C_I      :
               opcode == OP_LOAD   ? C_LOAD   :
               opcode == OP_STORE  ? C_STORE  :
               opcode == OP_BRANCH ? C_BRANCH :
               opcode == OP_JAL    ? C_JAL    :
               opcode == OP_JALR   ? C_JALR   :
               opcode == OP_SYSTEM ? C_SYS    : C_OTHER;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_op_dec.sv
// mc_alu_op_dec: maps opcode class, funct3 and funct7_5 to the execute-stage ALU opcode
module mc_alu_op_dec
    import mc_ctrl_fsm_pkg::*;
(
    input  op_class_e  cls,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_op
);

    function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? alu_SUB : alu_ADD;
            3'b001:  return alu_SLL;
            3'b010:  return alu_SLT;
            3'b011:  return alu_SLTU;
            3'b100:  return alu_XOR;
            3'b101:  return alt ? alu_SRA : alu_SRL;
            3'b110:  return alu_OR;
            default: return alu_AND;
        endcase
    endfunction

    // unsigned branch funct3 codes fold onto the signed compares
    function automatic logic [3:0] branch(input logic [2:0] f3);
        return f3[2] ? (f3[0] ? alu_BGE : alu_BLT) : (f3[0] ? alu_BNE : alu_BEQ);
    endfunction

    // immediate arithmetic only honours funct7_5 for shifts right
    always_comb begin
        alu_op = cls == C_R      ? arith(funct3, funct7_5) :
                 cls == C_I      ? arith(funct3, funct3 == 3'b101 && funct7_5) :
                 cls == C_BRANCH ? branch(funct3) : alu_ADD;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multi-cycle control FSM; MC_CTRL_PERF_CNT_EN adds cycle/instruction counters
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_op,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       wb_src,
    output logic       is_halted
`ifdef MC_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_e     state, state_nxt;
    op_class_e  cls;
    logic [3:0] ex_op;

    assign cls = op_class(opcode);

    mc_alu_op_dec u_dec (
        .cls      (cls),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_op   (ex_op)
    );

    // state register and sticky halt flag; reset drops any pending memory request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IF;
            is_halted <= 1'b0;
        end else begin
            state     <= state_nxt;
            is_halted <= is_halted | (state_nxt == S_HALT);
        end
    end

    // next-state and control strobes from current state and the held IR fields
    always_comb begin
        state_nxt    = state;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        i_or_d       = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'd0;
        alu_op       = alu_ADD;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        wb_src       = 1'b0;
        case (state)
            S_IF: begin
                mem_read  = 1'b1;
                ir_write  = mem_ready;
                state_nxt = mem_ready ? S_ID : S_IF;
            end
            S_ID: begin
                ab_write     = 1'b1;
                alu_src_b    = 2'd1;
                aluout_write = 1'b1;
                state_nxt    = cls == C_SYS ? (halt_req ? S_HALT : S_PCINC) : S_EX;
            end
            S_EX: begin
                alu_op = ex_op;
                case (cls)
                    C_R: begin
                        alu_src_a    = 1'b1;
                        aluout_write = 1'b1;
                        state_nxt    = S_WB;
                    end
                    C_I: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'd1;
                        aluout_write = 1'b1;
                        state_nxt    = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_a    = 1'b1;
                        alu_src_b    = 2'd1;
                        aluout_write = 1'b1;
                        state_nxt    = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_src_a = 1'b1;
                        pc_write  = bcond;
                        pc_src    = bcond ? 2'd1 : 2'd0;
                        state_nxt = bcond ? S_IF : S_PCINC;
                    end
                    C_JAL: begin
                        alu_src_b    = 2'd2;
                        aluout_write = 1'b1;
                        pc_write     = 1'b1;
                        pc_src       = 2'd1;
                        state_nxt    = S_WB;
                    end
                    C_JALR: begin
                        alu_src_b    = 2'd2;
                        aluout_write = 1'b1;
                        state_nxt    = S_JR;
                    end
                    default: state_nxt = S_PCINC;
                endcase
            end
            S_JR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd1;
                pc_write  = 1'b1;
                pc_src    = 2'd2;
                reg_write = 1'b1;
                state_nxt = S_IF;
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = cls == C_LOAD;
                mem_write = cls == C_STORE;
                mdr_write = mem_ready && cls == C_LOAD;
                state_nxt = !mem_ready ? S_MEM : cls == C_LOAD ? S_WB : S_PCINC;
            end
            S_WB: begin
                reg_write = 1'b1;
                wb_src    = cls == C_LOAD;
                alu_src_b = cls == C_JAL ? 2'd0 : 2'd2;
                pc_write  = cls != C_JAL;
                state_nxt = S_IF;
            end
            S_PCINC: begin
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_nxt = S_IF;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_IF;
        endcase
    end

`ifdef MC_CTRL_PERF_CNT_EN
    // counters run on every non-halted cycle; an instruction retires on re-entry to fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state != S_HALT) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (state_nxt == S_IF && state != S_IF)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle control FSM that sequences the single shared ALU through fetch, decode, execute, memory and write-back.
- Drives ALU operand selects and `alu_op`, register-enable strobes, and memory handshakes.
- Consumes the ALU `bcond` flag.
- Sits between instruction register/decode and the multi-cycle datapath in cpu top.

Parameters:
- STATE_W, 4, width of the state register.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset (0 = reset)
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- bcond  in  1  ALU branch result, valid in S_EX
- halt_req  in  1  ecall with x17==10, from register file
- mem_ready  in  1  memory completes the current request
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
- ir_write  out  1  load IR
- mdr_write  out  1  load MDR
- ab_write  out  1  load A/B operand registers
- aluout_write  out  1  load ALUOut
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = IMM, 2 = constant 4
- alu_op  out  4  ALU opcode, using the opcodes.v encodings
- pc_write  out  1  update PC
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1
- reg_write  out  1  write rd
- wb_src  out  1  0 = ALUOut, 1 = MDR
- is_halted  out  1  sticky halt flag

Behaviour:
- All outputs are Moore-decoded from state plus registered inputs. Any output not listed for a state is 0. Default `alu_op` is alu_ADD.
- Reset (reset==0 at a clk edge): state <= S_IF and is_halted <= 0. This takes priority in any state, including mid memory wait; the pending request is dropped.
- S_IF:
  - Outputs: mem_read=1, i_or_d=0.
  - Stays in S_IF while mem_ready==0.
  - On mem_ready: ir_write=1, next state S_ID.
- S_ID:
  - Outputs: ab_write=1, alu_src_a=PC, alu_src_b=IMM, ADD, aluout_write=1 (ALUOut becomes the branch/JAL target).
  - Opcode 1110011: go to S_HALT if halt_req, else S_PCINC.
  - Any other opcode: S_EX.
- S_EX:
  - R-type (0110011): A op B. alu_op comes from funct3/funct7_5; funct7_5 selects SUB vs ADD. aluout_write=1. Next S_WB.
  - I-arith (0010011): A op IMM; funct7_5 is ignored except for shifts. aluout_write=1. Next S_WB.
  - Load/store: A + IMM, aluout_write=1. Next S_MEM.
  - Branch (1100011): A vs B; alu_op is BEQ/BNE/BLT/BGE by funct3. funct3 110/111 map to BLT/BGE (unsigned branches are unsupported).
    - bcond==1: pc_write=1, pc_src=1, next S_IF.
    - bcond==0: next S_PCINC.
  - JAL: PC + 4 with aluout_write=1. In the same cycle pc_write=1, pc_src=1, using the old ALUOut target. Next S_WB.
  - JALR: PC + 4 with aluout_write=1. Next S_JR.
  - Unknown opcode: NOP, next S_PCINC.
- S_JR:
  - Outputs: A + IMM, pc_write=1, pc_src=2, reg_write=1, wb_src=0.
  - Next S_IF.
- S_MEM:
  - Outputs: i_or_d=1. mem_read=1 for load, mem_write=1 for store.
  - Holds until mem_ready.
  - Load: on mem_ready, mdr_write=1, next S_WB.
  - Store: on mem_ready, next S_PCINC.
- S_WB:
  - Outputs: reg_write=1, wb_src = load ? 1 : 0.
  - Except after JAL: ALU computes PC + 4, pc_write=1, pc_src=0.
  - Next S_IF.
- S_PCINC:
  - Outputs: PC + 4, pc_write=1, pc_src=0.
  - Next S_IF.
- S_HALT: is_halted=1; absorbing until reset. No memory or register strobes.
- Latency in cycles, excluding memory wait:
  - R/I: 4
  - load: 5
  - store: 5
  - branch taken: 3
  - branch not-taken: 4
  - JAL: 4
  - JALR: 4
- Each memory state adds one cycle per cycle that mem_ready stays low.
- mem_read/mem_write are held stable until mem_ready is sampled high.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs cycle_cnt[CNT_W] and instr_cnt[CNT_W], both reset to 0.
  - cycle_cnt increments every non-halted cycle.
  - instr_cnt increments on every transition into S_IF from a non-IF state.
  - Both counters wrap modulo 2^CNT_W and freeze in S_HALT.
- When undefined: the ports and logic are absent.

Decomposition:
- opcodes.v holds the state encodings, opcode constants and alu_* encodings.
- One sub-module, mc_alu_op_dec: combinational {opcode class, funct3, funct7_5} -> alu_op.

Test Plan:
- Reset low for 2 cycles in S_MEM with mem_read=1 -> next cycle is S_IF; is_halted=0; mem_read asserted with i_or_d=0.
- R-type SUB (funct7_5=1, funct3=000), mem_ready tied 1 -> alu_op=alu_SUB in S_EX; reg_write in cycle 4; pc_write with pc_src=0 in the same cycle.
- Load with mem_ready low for 3 cycles in S_MEM -> mem_read held 4 cycles; mdr_write once; 8 cycles total.
- BEQ with bcond=1 -> pc_write with pc_src=1 in cycle 3, then IF; with bcond=0 -> S_PCINC, 4 cycles.
- JALR -> S_JR asserts pc_src=2, reg_write=1, wb_src=0 in the same cycle.
- ecall with halt_req=1 -> is_halted=1 from cycle 3; no strobes for the next 10 cycles; counters (if enabled) freeze.
